// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: the hex glyph table,
// the dark segment pattern and a helper that builds the idle anode mask.
package sseg_pkg;

    // Glyphs for hex values F down to 0, listed so that SEG_TABLE[n] is the pattern for nibble n.
    // Bit 6 is segment a and bit 0 is segment g. All segments are active low.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,
        7'b0110000,
        7'b1000010,
        7'b0110001,
        7'b1100000,
        7'b0001000,
        7'b0000100,
        7'b0000000,
        7'b0001111,
        7'b0100000,
        7'b0100100,
        7'b1001100,
        7'b0000110,
        7'b0010010,
        7'b1001111,
        7'b0000001
    };

    // Segment pattern that turns every segment a..g off.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Idle anode mask for up to eight digits: the low num_digits bits are set, so every anode is off.
    function automatic logic [7:0] AN_OFF(input int unsigned num_digits);
        logic [8:0] mask;
        mask = 9'd1 << num_digits;
        return 8'(mask - 9'd1);
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low a..g segment decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // A plain table lookup keeps this decoder identical to the package glyph set.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller.
// Digit updates are double-buffered so that a whole frame always shows a
// consistent value. The controller also supports PWM brightness, per-digit
// blank and blink, leading-zero suppression and a frame-done pulse.
// BRIGHT_W must not exceed SLOT_W.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_W     = 16,
    parameter int BRIGHT_W   = 3,
    parameter int BLINK_W    = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg,
    output logic                    frame_done
);

    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [7:0]            AN_ALL   = AN_OFF(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ALL[NUM_DIGITS-1:0];
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]       count;
    logic [IDX_W-1:0]        idx;
    logic [BLINK_W:0]        blink_cnt;
    logic                    slot_end;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [NUM_DIGITS-1:0]   pend_blink;
    logic                    pending_valid;

    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [NUM_DIGITS-1:0]   act_blink;

    logic [NUM_DIGITS-1:0]   suppressed;
    logic                    lz_run;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_seg;
    logic                    pwm_on;
    logic                    lit;

    assign slot_end  = &count;
    assign frame_end = slot_end && (idx == LAST_IDX);

    // Timing chain. A free-running slot prescaler advances the digit index at the
    // end of each slot, and the index wrap counts frames for the blink phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
        end else begin
            count <= count + SLOT_W'(1);
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            if (frame_end) begin
                blink_cnt <= blink_cnt + (BLINK_W + 1)'(1);
            end
        end
    end

    // Double buffer. Loads land in the pending copy and are promoted only at a
    // frame boundary. A load coinciding with the boundary goes straight to the
    // active copy, so no older pending frame can sneak in afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_digits   <= '0;
            pend_dp       <= '0;
            pend_blank    <= '0;
            pend_blink    <= '0;
            pending_valid <= 1'b0;
            act_digits    <= '0;
            act_dp        <= '0;
            act_blank     <= '1;
            act_blink     <= '0;
        end else if (load && frame_end) begin
            pend_digits   <= digits_in;
            pend_dp       <= dp_in;
            pend_blank    <= blank_in;
            pend_blink    <= blink_in;
            pending_valid <= 1'b0;
            act_digits    <= digits_in;
            act_dp        <= dp_in;
            act_blank     <= blank_in;
            act_blink     <= blink_in;
        end else if (load) begin
            pend_digits   <= digits_in;
            pend_dp       <= dp_in;
            pend_blank    <= blank_in;
            pend_blink    <= blink_in;
            pending_valid <= 1'b1;
        end else if (frame_end && pending_valid) begin
            act_digits    <= pend_digits;
            act_dp        <= pend_dp;
            act_blank     <= pend_blank;
            act_blink     <= pend_blink;
            pending_valid <= 1'b0;
        end
    end

    // Leading-zero suppression. The scan runs from the leftmost digit down and
    // stops at the first non-zero nibble or lit decimal point. Digit 0 always
    // stays visible, so a value of zero still shows "0".
    always_comb begin
        suppressed = '0;
        lz_run     = lz_suppress;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run && (act_digits[4*i +: 4] == 4'h0) && !act_dp[i];
            if (i != 0) begin
                suppressed[i] = lz_run;
            end
        end
    end

    // Decide whether the digit under scan is lit this cycle. PWM gates on the top
    // bits of the slot counter, and an all-ones brightness means always on.
    always_comb begin
        cur_nibble = act_digits[{idx, 2'b00} +: 4];
        pwm_on     = (&brightness) || (count[SLOT_W-1 -: BRIGHT_W] < brightness);
        lit        = !act_blank[idx] && !suppressed[idx] &&
                     !(act_blink[idx] && blink_cnt[BLINK_W]) && pwm_on;
    end

    hex_to_sseg u_hex_to_sseg (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Registered pin drivers, so the board sees glitch-free anode and segment lines.
    // The frame-done pulse is aligned with these registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            an         <= AN_IDLE;
            sseg       <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (lit) begin
                an   <= ~(NUM_DIGITS'(1) << idx);
                sseg <= {~act_dp[idx], cur_seg};
            end else begin
                an   <= AN_IDLE;
                sseg <= {1'b1, SEG_OFF};
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed self-checking bench for sseg_scan_ctrl.
// It uses 16-cycle slots and 64-cycle frames, 3-bit brightness and a 4-frame blink period.
module tb_sseg_scan_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int SLOT_W     = 4;
    localparam int BRIGHT_W   = 3;
    localparam int BLINK_W    = 1;

    // Hand-decoded glyphs per shown value, listed from digit 3 down to digit 0.
    localparam logic [3:0][6:0] SEG_1234 = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
    localparam logic [3:0][6:0] SEG_ABCD = {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010};
    localparam logic [3:0][6:0] SEG_0F1E = {7'b0000001, 7'b0111000, 7'b1001111, 7'b0110000};
    localparam logic [3:0][6:0] SEG_0050 = {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001};
    localparam logic [3:0][6:0] SEG_4321 = {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};

    logic                    clk;
    logic                    reset_n;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic                    load;
    logic [BRIGHT_W-1:0]     brightness;
    logic                    lz_suppress;
    logic [NUM_DIGITS-1:0]   an;
    logic [7:0]              sseg;
    logic                    frame_done;

    int checkCount = 0;
    int errorCount = 0;

    sseg_scan_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .SLOT_W     (SLOT_W),
        .BRIGHT_W   (BRIGHT_W),
        .BLINK_W    (BLINK_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .blink_in    (blink_in),
        .load        (load),
        .brightness  (brightness),
        .lz_suppress (lz_suppress),
        .an          (an),
        .sseg        (sseg),
        .frame_done  (frame_done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge. Stimulus is driven and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count a comparison and report it if the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the inputs that are not digit values.
    // Brightness and lz_suppress act at once. The other three are captured on load.
    task automatic applyStimulus(input logic [3:0] dp, input logic [3:0] blank, input logic [3:0] blink,
                                 input logic [2:0] bright, input logic lz);
        dp_in       = dp;
        blank_in    = blank;
        blink_in    = blink;
        brightness  = bright;
        lz_suppress = lz;
    endtask

    // Check one full 64-cycle frame, starting just after frame_done was seen.
    // Within each 16-cycle slot a digit in litMask is lit for its first onCycles cycles.
    // The optional loads are sampled on the edge after step at0 or at1. Step 63
    // therefore coincides with the frame-end edge.
    task automatic checkFrame(input string tag, input logic [3:0][6:0] segs, input logic [3:0] dps,
                              input logic [3:0] litMask, input int onCycles,
                              input int at0, input logic [15:0] v0, input int at1, input logic [15:0] v1);
        int          k;
        int          c;
        logic        litExp;
        logic [3:0]  expAn;
        logic [7:0]  expSseg;
        for (int j = 1; j <= 64; j++) begin
            tick();
            load    = 1'b0;
            k       = (j - 1) / 16;
            c       = (j - 1) % 16;
            litExp  = litMask[k] && (c < onCycles);
            expAn   = 4'hF;
            expSseg = 8'hFF;
            if (litExp) begin
                expAn[k] = 1'b0;
                expSseg  = {~dps[k], segs[k]};
            end
            checkOutput($sformatf("%s an j%0d", tag, j), 32'(an), 32'(expAn));
            checkOutput($sformatf("%s sseg j%0d", tag, j), 32'(sseg), 32'(expSseg));
            checkOutput($sformatf("%s frame_done j%0d", tag, j), 32'(frame_done), 32'(j == 64));
            if (j == at0) begin
                digits_in = v0;
                load      = 1'b1;
            end
            if (j == at1) begin
                digits_in = v1;
                load      = 1'b1;
            end
        end
    endtask

    // Directed sequence. Frame numbers count from the release of reset,
    // and the blink-off phase falls on frames 2 and 3 modulo 4.
    initial begin
        reset_n   = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 3'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset an", 32'(an), 32'hF);
            checkOutput("reset sseg", 32'(sseg), 32'hFF);
            checkOutput("reset frame_done", 32'(frame_done), 32'h0);
        end
        reset_n   = 1'b1;
        digits_in = 16'h1234;
        load      = 1'b1;

        checkFrame("f0 dark", '0, 4'b0000, 4'b0000, 16, -1, 16'h0, -1, 16'h0);
        checkFrame("f1 scan", SEG_1234, 4'b0000, 4'b1111, 16, 20, 16'hABCD, -1, 16'h0);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 3'd7, 1'b0);
        checkFrame("f2 atomic", SEG_ABCD, 4'b0000, 4'b1111, 16, 10, 16'h9876, 63, 16'h0F1E);
        checkFrame("f3 same-cycle", SEG_0F1E, 4'b0100, 4'b1111, 16, -1, 16'h0, -1, 16'h0);
        checkFrame("f4 no-stale", SEG_0F1E, 4'b0100, 4'b1111, 16, -1, 16'h0, -1, 16'h0);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 3'd2, 1'b0);
        checkFrame("f5 pwm2", SEG_0F1E, 4'b0100, 4'b1111, 4, -1, 16'h0, -1, 16'h0);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 3'd0, 1'b0);
        checkFrame("f6 pwm0", SEG_0F1E, 4'b0100, 4'b1111, 0, -1, 16'h0, -1, 16'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 3'd7, 1'b0);
        checkFrame("f7 full", SEG_0F1E, 4'b0100, 4'b1111, 16, 5, 16'h0050, -1, 16'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 3'd7, 1'b1);
        checkFrame("f8 lz", SEG_0050, 4'b0000, 4'b0011, 16, 5, 16'h4321, -1, 16'h0);
        checkFrame("f9 blink on", SEG_4321, 4'b0000, 4'b1111, 16, -1, 16'h0, -1, 16'h0);
        checkFrame("f10 blink off", SEG_4321, 4'b0000, 4'b1110, 16, -1, 16'h0, -1, 16'h0);
        checkFrame("f11 blink off", SEG_4321, 4'b0000, 4'b1110, 16, -1, 16'h0, -1, 16'h0);
        applyStimulus(4'b0000, 4'b1000, 4'b0001, 3'd7, 1'b1);
        checkFrame("f12 blink on", SEG_4321, 4'b0000, 4'b1111, 16, 5, 16'h4321, -1, 16'h0);
        checkFrame("f13 blank", SEG_4321, 4'b0000, 4'b0111, 16, -1, 16'h0, -1, 16'h0);

        repeat (7) tick();
        digits_in = 16'h8888;
        load      = 1'b1;
        tick();
        load    = 1'b0;
        reset_n = 1'b0;
        tick();
        checkOutput("mid reset an", 32'(an), 32'hF);
        checkOutput("mid reset sseg", 32'(sseg), 32'hFF);
        checkOutput("mid reset frame_done", 32'(frame_done), 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        checkFrame("r0 dark", '0, 4'b0000, 4'b0000, 16, -1, 16'h0, -1, 16'h0);
        checkFrame("r1 dark", '0, 4'b0000, 4'b0000, 16, -1, 16'h0, -1, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
